// File: rtl/enc_op_scheduler.sv
// Instruction scheduler for the encryption datapath.
// Wishbone slave front end: instruction push register, status/sticky-clear
// register, and a pass-through ack for host SRAM accesses that is gated by
// SRAM ownership. Accepted instructions queue in a small FIFO and are handed
// to the datapath one at a time through a valid/ready + done handshake.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no operation in flight; pops the queue head when non-empty
//   ST_ISSUE | op_valid_o high, op_* held until the datapath takes it
//   ST_WAIT  | datapath owns SRAM and is executing; waits for op_done_i
module enc_op_scheduler #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h3000_0004
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic [1:0]            op_code_o,
    output logic [ADDR_WIDTH-1:0] op_src0_o,
    output logic [ADDR_WIDTH-1:0] op_src1_o,
    output logic [ADDR_WIDTH-1:0] op_dst_o,
    input  logic                  op_done_i,
    output logic                  host_mem_grant_o,
    output logic                  busy_o
);

    localparam int INSTR_W = 2 + 3 * ADDR_WIDTH;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;

    logic                 req;
    logic                 hit_op;
    logic                 hit_st;
    logic                 hit_mem;
    logic                 accept;
    logic                 clr_ovf;
    logic                 clr_err;

    logic                 ack_q, ack_d;
    logic                 served_q, served_d;
    logic [31:0]          dat_q, dat_d;
    logic                 push_q, push_d;
    logic [INSTR_W-1:0]   push_word_q, push_word_d;

    logic                 push_rsvd;
    logic                 push_valid;
    logic                 fifo_wr;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [31:0]          status_word;

    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    logic [INSTR_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [INSTR_W-1:0]   op_word_q, op_word_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_empty  = (count_q == '0);
    assign status_word = {16'h0000, 8'(count_q), 3'b000, err_q, ovf_q,
                          busy_o, fifo_empty, fifo_full};

    // Decode the bus request; SRAM accesses are only taken while the host owns SRAM.
    always_comb begin
        req     = wbs_stb_i & wbs_cyc_i;
        hit_op  = (wbs_adr_i == OPCODE_ADDR);
        hit_st  = (wbs_adr_i == STATUS_ADDR);
        hit_mem = ~hit_op & ~hit_st;
        accept  = req & ~served_q & (~hit_mem | host_mem_grant_o);
    end

    // Bus response: one ack per request, read data only for the status register.
    // A push is carried into the ack cycle and lands in the queue at its end.
    always_comb begin
        ack_d       = accept;
        served_d    = req & (served_q | accept);
        push_d      = accept & wbs_we_i & hit_op;
        push_word_d = push_word_q;
        if (push_d) begin
            push_word_d = wbs_dat_i[INSTR_W-1:0];
        end
        dat_d = '0;
        if (accept & ~wbs_we_i & hit_st) begin
            dat_d = status_word;
        end
        clr_ovf = accept & wbs_we_i & hit_st & wbs_dat_i[3];
        clr_err = accept & wbs_we_i & hit_st & wbs_dat_i[4];
    end

    // Queue write and sticky flags; a pop in the same cycle frees room for a push.
    always_comb begin
        push_rsvd  = push_q & (push_word_q[1:0] == 2'b11);
        push_valid = push_q & ~push_rsvd;
        fifo_wr    = push_valid & (~fifo_full | pop);

        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push_valid & fifo_full & ~pop) begin
            ovf_d = 1'b1;
        end

        err_d = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (push_rsvd) begin
            err_d = 1'b1;
        end
    end

    // Queue pointers and occupancy.
    always_comb begin
        wr_ptr_d = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({fifo_wr, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Dispatch FSM next state; popping loads the op_* holding register.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        op_word_d = op_word_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    op_word_d = mem_q[rd_ptr_q];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (op_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Queue storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge wb_clk_i) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= push_word_q;
        end
    end

    // Register update for bus, queue, flags and FSM.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            served_q    <= 1'b0;
            dat_q       <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_word_q   <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            served_q    <= served_d;
            dat_q       <= dat_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_word_q   <= op_word_d;
        end
    end

    assign wbs_ack_o        = ack_q;
    assign wbs_dat_o        = dat_q;
    assign op_valid_o       = (state_q == ST_ISSUE);
    assign busy_o           = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
    assign host_mem_grant_o = (state_q == ST_IDLE) & fifo_empty;
    assign op_code_o        = op_word_q[1:0];
    assign op_src0_o        = op_word_q[2 +: ADDR_WIDTH];
    assign op_src1_o        = op_word_q[2 + ADDR_WIDTH +: ADDR_WIDTH];
    assign op_dst_o         = op_word_q[2 + 2 * ADDR_WIDTH +: ADDR_WIDTH];

endmodule

// File: tb/tb_enc_op_scheduler.sv
// Bench for enc_op_scheduler: reset values, a table of single-instruction
// dispatches, hand sequences for queue-full / stall / reset corners, and
// randomized rounds checked against a queue-based model.
module tb_enc_op_scheduler;

    localparam logic [31:0] OP_A  = 32'h3000_0000;
    localparam logic [31:0] ST_A  = 32'h3000_0004;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic        op_done = 1'b0;
    logic [1:0]  op_code;
    logic [9:0]  src0, src1, dst;
    logic        grant, busy;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];

    bit          m_ovf, m_err, m_infl;
    logic [31:0] m_infl_w;
    logic [31:0] mq[$];

    typedef struct {
        logic [31:0] word;
        bit          disp;
        logic [1:0]  code;
        logic [9:0]  s0;
        logic [9:0]  s1;
        logic [9:0]  d;
    } vec_t;

    vec_t tv[5];

    enc_op_scheduler dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst_n),
        .wbs_stb_i        (stb),
        .wbs_cyc_i        (cyc),
        .wbs_we_i         (we),
        .wbs_adr_i        (adr),
        .wbs_dat_i        (wdat),
        .wbs_ack_o        (ack),
        .wbs_dat_o        (rdat),
        .op_valid_o       (op_valid),
        .op_ready_i       (op_ready),
        .op_code_o        (op_code),
        .op_src0_o        (src0),
        .op_src1_o        (src1),
        .op_dst_o         (dst),
        .op_done_i        (op_done),
        .host_mem_grant_o (grant),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no response expected one within budget", name);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [9:0] s0,
                                       input logic [9:0] s1, input logic [9:0] d);
        return {d, s1, s0, op};
    endfunction

    function automatic logic [31:0] stat(input int cnt, input bit e, input bit o, input bit b);
        logic [7:0] c8;
        c8 = 8'(cnt);
        return {16'h0000, c8, 3'b000, e, o, b, (cnt == 0), (cnt == DEPTH)};
    endfunction

    // Single bus transfer; returns at the falling edge of the ack cycle.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        int t;
        repeat (2) @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ack && t < 20);
        if (!ack) note_timeout("wb_ack");
        rd = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        logic [31:0] dummy;
        wb_xfer(1'b1, OP_A, w, dummy);
    endtask

    task automatic read_status(output logic [31:0] s);
        wb_xfer(1'b0, ST_A, 32'h0, s);
    endtask

    // Act as the datapath for every word in exp_q, checking order and fields.
    task automatic drain();
        logic [31:0] w;
        int t;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            t = 0;
            while (!op_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!op_valid) begin
                note_timeout("dispatch");
                exp_q.delete();
                return;
            end
            chk("op_code", 32'(op_code), 32'(w[1:0]));
            chk("op_src0", 32'(src0), 32'(w[11:2]));
            chk("op_src1", 32'(src1), 32'(w[21:12]));
            chk("op_dst", 32'(dst), 32'(w[31:22]));
            chk("busy_issue", 32'(busy), 32'd1);
            chk("grant_issue", 32'(grant), 32'd0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("valid_hold", 32'(op_valid), 32'd1);
            end
            op_ready = 1'b1;
            @(negedge clk);
            op_ready = 1'b0;
            chk("valid_wait", 32'(op_valid), 32'd0);
            chk("busy_wait", 32'(busy), 32'd1);
            chk("grant_wait", 32'(grant), 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op_done = 1'b1;
            @(negedge clk);
            op_done = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] s, rd, w;
        int t;
        bit seen;

        tv[0] = '{32'h0C86_4000, 1'b1, 2'd0, 10'd0,    10'd100, 10'd50};
        tv[1] = '{32'hFFC0_0FFD, 1'b1, 2'd1, 10'd1023, 10'd0,   10'd1023};
        tv[2] = '{32'h0240_7016, 1'b1, 2'd2, 10'd5,    10'd7,   10'd9};
        tv[3] = '{32'h0060_1800, 1'b1, 2'd0, 10'd512,  10'd513, 10'd1};
        tv[4] = '{32'hFFFF_FFFF, 1'b0, 2'd0, 10'd0,    10'd0,   10'd0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_fields", {20'(src0 | src1 | dst), 10'd0, op_code}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: single pushes, latency, fields, reserved opcode
        for (int i = 0; i < 5; i++) begin
            push(tv[i].word);
            if (tv[i].disp) begin
                @(negedge clk);
                chk("lat_n1_valid", 32'(op_valid), 32'd0);
                chk("lat_n1_grant", 32'(grant), 32'd0);
                @(negedge clk);
                chk("lat_n2_valid", 32'(op_valid), 32'd1);
                chk("tbl_code", 32'(op_code), 32'(tv[i].code));
                chk("tbl_src0", 32'(src0), 32'(tv[i].s0));
                chk("tbl_src1", 32'(src1), 32'(tv[i].s1));
                chk("tbl_dst", 32'(dst), 32'(tv[i].d));
                exp_q.push_back(tv[i].word);
                drain();
                read_status(s);
                chk("tbl_status_idle", s, stat(0, 0, 0, 0));
            end else begin
                seen = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (op_valid) seen = 1'b1;
                end
                chk("rsvd_no_dispatch", 32'(seen), 32'd0);
                read_status(s);
                chk("rsvd_status", s, stat(0, 1, 0, 0));
                wb_xfer(1'b1, ST_A, 32'h10, rd);
                read_status(s);
                chk("rsvd_err_clr", s, stat(0, 0, 0, 0));
            end
        end

        // Held strobe: one ack and one push per request
        w = mk(2'd1, 10'd11, 10'd22, 10'd33);
        repeat (2) @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = OP_A; wdat = w;
        t = 0;
        do begin @(negedge clk); t++; end while (!ack && t < 20);
        if (!ack) note_timeout("held_ack");
        repeat (3) begin
            @(negedge clk);
            chk("held_no_reack", 32'(ack), 32'd0);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        read_status(s);
        chk("held_single_push", s, stat(0, 0, 0, 1));
        exp_q.push_back(w);
        drain();

        // Queue full, overflow, clear, then push-while-full with same-cycle pop
        for (int i = 0; i < 6; i++) begin
            push(mk(2'(i % 3), 10'(i), 10'(i + 100), 10'(200 + i)));
            if (i == 4) begin
                read_status(s);
                chk("full_status", s, stat(4, 0, 0, 1));
            end
        end
        read_status(s);
        chk("ovf_status", s, stat(4, 0, 1, 1));
        wb_xfer(1'b1, ST_A, 32'h8, rd);
        read_status(s);
        chk("ovf_clr", s, stat(4, 0, 0, 1));
        chk("ovf_valid_first", 32'(op_valid), 32'd1);
        chk("ovf_first_dst", 32'(dst), 32'd200);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("ovf_in_wait", 32'(op_valid), 32'd0);
        w = mk(2'd2, 10'd7, 10'd8, 10'd299);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = OP_A; wdat = w;
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        chk("pushpop_ack", 32'(ack), 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        read_status(s);
        chk("pushpop_status", s, stat(4, 0, 0, 1));
        for (int i = 1; i < 5; i++) exp_q.push_back(mk(2'(i % 3), 10'(i), 10'(i + 100), 10'(200 + i)));
        exp_q.push_back(w);
        drain();
        read_status(s);
        chk("pushpop_drained", s, stat(0, 0, 0, 0));

        // Host SRAM access stalls while the datapath owns SRAM
        push(mk(2'd0, 10'd1, 10'd2, 10'd3));
        repeat (2) @(negedge clk);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'd50; wdat = 32'hDEAD_BEEF;
        repeat (5) begin
            @(negedge clk);
            chk("stall_ack", 32'(ack), 32'd0);
            chk("stall_grant", 32'(grant), 32'd0);
        end
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        chk("stall_idle_grant", 32'(grant), 32'd1);
        chk("stall_idle_ack", 32'(ack), 32'd0);
        @(negedge clk);
        chk("stall_release_ack", 32'(ack), 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("stall_ack_pulse", 32'(ack), 32'd0);

        // Dispatch order 50, 51, 52
        exp_q.push_back(mk(2'd0, 10'd1, 10'd2, 10'd50));
        exp_q.push_back(mk(2'd1, 10'd3, 10'd4, 10'd51));
        exp_q.push_back(mk(2'd2, 10'd5, 10'd6, 10'd52));
        for (int i = 0; i < 3; i++) push(exp_q[i]);
        drain();
        repeat (2) @(negedge clk);
        chk("order_busy_end", 32'(busy), 32'd0);
        read_status(s);
        chk("order_status_end", s, stat(0, 0, 0, 0));

        // Reset in WAIT with two queued
        push(mk(2'd0, 10'd9, 10'd9, 10'd9));
        repeat (2) @(negedge clk);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        push(mk(2'd1, 10'd8, 10'd8, 10'd8));
        push(mk(2'd2, 10'd7, 10'd7, 10'd7));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(op_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_grant", 32'(grant), 32'd1);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_dat", rdat, 32'd0);
        chk("arst_fields", {20'(src0 | src1 | dst), 10'd0, op_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (op_valid) seen = 1'b1;
        end
        chk("arst_no_dispatch", 32'(seen), 32'd0);
        read_status(s);
        chk("arst_status", s, stat(0, 0, 0, 0));

        // Randomized rounds against the queue model
        m_ovf = 1'b0;
        m_err = 1'b0;
        for (int r = 0; r < 25; r++) begin
            m_infl = 1'b0;
            mq.delete();
            repeat ($urandom_range(1, 8)) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: begin
                        w = $urandom;
                        if ($urandom_range(0, 3) == 0) w[1:0] = 2'b11;
                        push(w);
                        if (w[1:0] == 2'b11) m_err = 1'b1;
                        else if (!m_infl) begin
                            m_infl = 1'b1;
                            m_infl_w = w;
                        end else if (mq.size() < DEPTH) mq.push_back(w);
                        else m_ovf = 1'b1;
                    end
                    6, 7: begin
                        read_status(s);
                        chk("rnd_status", s, stat(mq.size(), m_err, m_ovf, m_infl));
                    end
                    8: begin
                        w = $urandom;
                        wb_xfer(1'b1, ST_A, w, rd);
                        if (w[3]) m_ovf = 1'b0;
                        if (w[4]) m_err = 1'b0;
                    end
                    default: begin
                        @(negedge clk);
                        op_done = 1'b1;
                        @(negedge clk);
                        op_done = 1'b0;
                    end
                endcase
            end
            read_status(s);
            chk("rnd_pre_drain", s, stat(mq.size(), m_err, m_ovf, m_infl));
            if (m_infl) exp_q.push_back(m_infl_w);
            foreach (mq[k]) exp_q.push_back(mq[k]);
            drain();
            read_status(s);
            chk("rnd_post_drain", s, stat(0, m_err, m_ovf, 0));
            chk("rnd_grant_idle", 32'(grant), 32'd1);
            wb_xfer(1'b0, 32'(1000 + $urandom_range(0, 1023)), 32'h0, rd);
            chk("rnd_sram_rdata", rd, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_op_scheduler.md
ENC_OP_SCHEDULER -- requirements
Module: enc_op_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, width of each operand address field.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction queue entries (power of 2).
REQ-003 Parameter OPCODE_ADDR, default 32'h30000000, Wishbone address for instruction push.
REQ-004 Parameter STATUS_ADDR, default 32'h30000004, Wishbone address for status read / sticky-clear write.
REQ-005 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-006 wb_rst_i  in  1  reset, asynchronous assert, active-low.
REQ-007 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
REQ-008 wbs_adr_i  in  32, wbs_dat_i  in  32  Wishbone address, write data.
REQ-009 wbs_ack_o  out  1, wbs_dat_o  out  32  Wishbone acknowledge, read data.
REQ-010 op_valid_o  out  1, op_ready_i  in  1  dispatch handshake to encryption datapath.
REQ-011 op_code_o  out  2; op_src0_o, op_src1_o, op_dst_o  out  ADDR_WIDTH each  dispatched instruction fields.
REQ-012 op_done_i  in  1  one-cycle pulse from datapath: current operation complete.
REQ-013 host_mem_grant_o  out  1  1 = host owns shared SRAM port, 0 = datapath owns it.
REQ-014 busy_o  out  1  high in ISSUE or WAIT.

Function
REQ-015 Instruction word: [1:0] opcode, [11:2] src0, [21:12] src1, [31:22] dst (ADDR_WIDTH=10).
REQ-016 Opcodes: 00 encrypt, 01 decrypt, 10 homomorphic add, 11 reserved.
REQ-017 wbs_ack_o pulses high exactly one cycle, the cycle after a qualified request (stb&cyc), then low until stb drops and a new request arrives.
REQ-018 Write to OPCODE_ADDR: push word if not full; if full, drop word, set sticky ovf; opcode 11: drop word, set sticky err; ack in all cases.
REQ-019 Read of STATUS_ADDR: {16'b0, count[7:0], 3'b0, err, ovf, busy, empty, full} at bits [31:0]; acked per REQ-017.
REQ-020 Write to STATUS_ADDR with wbs_dat_i[3]=1 clears ovf; wbs_dat_i[4]=1 clears err.
REQ-021 Any other address = host SRAM access: acked only when host_mem_grant_o=1; otherwise ack withheld (stall) until grant returns; wbs_dat_o = 0 for this block.
REQ-022 FSM states IDLE, ISSUE, WAIT.
REQ-023 IDLE: queue non-empty -> pop head into op_* registers, go ISSUE next cycle; else stay.
REQ-024 ISSUE: op_valid_o=1, op_* stable; op_valid_o & op_ready_i -> WAIT.
REQ-025 WAIT: op_valid_o=0; op_done_i -> IDLE; op_done_i in IDLE/ISSUE ignored.
REQ-026 Minimum issue latency: push acked cycle N -> op_valid_o high cycle N+2 when IDLE and queue empty.
REQ-027 host_mem_grant_o = 1 only in IDLE with no pending pop; 0 from the cycle IDLE pops through the cycle WAIT sees op_done_i.
REQ-028 Simultaneous push and pop: both occur, count unchanged; push when full with same-cycle pop is accepted, not ovf.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-030 Dispatch order strictly FIFO.

Reset
REQ-031 While wb_rst_i=0: state IDLE, queue empty, count 0, ovf=err=0, wbs_ack_o=0, wbs_dat_o=0, op_valid_o=0, op_* fields 0, busy_o=0, host_mem_grant_o=1.
REQ-032 Reset mid-operation (ISSUE/WAIT) discards in-flight and queued instructions; no op_valid_o after release until a new push.

Verification
REQ-033 Push 32'h0C864000 to OPCODE_ADDR, op_ready_i=1 -> op_valid_o one cycle with op_code 00, src0 0, src1 100, dst 50; busy_o=1, grant=0 until op_done_i.
REQ-034 Push 5 valid words with op_ready_i=0 -> first popped, 4 queued, status full=1, count=4, 5th... 6th push sets ovf=1; write STATUS_ADDR data 32'h8 -> ovf=0.
REQ-035 Push opcode 11 -> no dispatch, status err=1, count unchanged.
REQ-036 Host write to address 50 while in WAIT -> ack withheld; op_done_i pulse -> ack one cycle after return to IDLE, grant=1.
REQ-037 Three pushes (dst 50, 51, 52), done after each -> dispatch order 50, 51, 52; queue empty, busy_o=0 at end.
REQ-038 Assert wb_rst_i=0 in WAIT with 2 queued -> all outputs at REQ-031 values immediately; no dispatch after release.
